// File: rtl/cart_upload_if.sv
// cart_upload_if: HPS ioctl read port plus SDRAM read channel used by cart_upload
interface cart_upload_if;
    logic        upload_active;
    logic [26:0] ioctl_addr;
    logic        ioctl_rd;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        sdram_req;
    logic [26:0] sdram_addr;
    logic        sdram_rnw;
    logic        sdram_ready;
    logic [31:0] sdram_dout;
    modport slave (
        input  upload_active, ioctl_addr, ioctl_rd, sdram_ready, sdram_dout,
        output ioctl_din, ioctl_wait, sdram_req, sdram_addr, sdram_rnw
    );
    modport master (
        output upload_active, ioctl_addr, ioctl_rd, sdram_ready, sdram_dout,
        input  ioctl_din, ioctl_wait, sdram_req, sdram_addr, sdram_rnw
    );
endinterface

// File: rtl/cart_upload.sv
// cart_upload: serves HPS 16-bit upload reads from a one-word SDRAM cache; CART_UPLOAD_PREFETCH_EN adds next-word prefetch
module cart_upload #(
    parameter logic [26:0] BASE_ADDR = 27'd8388608
) (
    input  logic         clk1x,
    input  logic         reset,
    cart_upload_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        wait_q, wait_d, req_q, req_d, valid_q, valid_d;
    logic        act_q, act_d, pf_q, pf_d, pend_q, pend_d;
    logic [15:0] din_q, din_d;
    logic [26:0] saddr_q, saddr_d, raddr_q, raddr_d;
    logic [31:0] cache_q, cache_d;
    logic [24:0] caddr_q, caddr_d, fa_q, fa_d;
    logic        hit, pend_w;
    logic [26:0] addr_w;
    logic [15:0] fill_half;

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.sdram_req  = req_q;
    assign bus.sdram_addr = saddr_q;
    assign bus.sdram_rnw  = 1'b1;

    // Next-state: hit/miss decode in IDLE, fill or discard on SDRAM completion, abort on upload end
    always_comb begin
        hit       = bus.upload_active && act_q && valid_q && caddr_q == bus.ioctl_addr[26:2];
        pend_w    = pend_q || (pf_q && bus.ioctl_rd);
        addr_w    = (pf_q && !pend_q && bus.ioctl_rd) ? bus.ioctl_addr : raddr_q;
        fill_half = addr_w[1] ? bus.sdram_dout[31:16] : bus.sdram_dout[15:0];
        state_d   = state_q;
        wait_d    = wait_q;
        req_d     = 1'b0;
        valid_d   = valid_q;
        act_d     = bus.upload_active;
        pf_d      = pf_q;
        pend_d    = pend_q;
        din_d     = din_q;
        saddr_d   = saddr_q;
        raddr_d   = raddr_q;
        cache_d   = cache_q;
        caddr_d   = caddr_q;
        fa_d      = fa_q;
        if (bus.upload_active && !act_q) valid_d = 1'b0;
        case (state_q)
            IDLE: if (bus.ioctl_rd) begin
                raddr_d = bus.ioctl_addr;
                if (hit) begin
                    din_d = bus.ioctl_addr[1] ? cache_q[31:16] : cache_q[15:0];
`ifdef CART_UPLOAD_PREFETCH_EN
                    if (bus.ioctl_addr[1]) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        pf_d    = 1'b1;
                        fa_d    = caddr_q + 25'd1;
                    end
`endif
                end else begin
                    wait_d  = 1'b1;
                    req_d   = 1'b1;
                    fa_d    = bus.ioctl_addr[26:2];
                    state_d = REQ;
                end
            end
            REQ, WAIT: if (!bus.upload_active) begin
                wait_d  = 1'b0;
                valid_d = 1'b0;
                pend_d  = 1'b0;
                state_d = DRAIN;
            end else if (state_q == REQ || !bus.sdram_ready) begin
                if (state_q == REQ) state_d = WAIT;
                if (pf_q && bus.ioctl_rd) begin
                    pend_d  = 1'b1;
                    raddr_d = bus.ioctl_addr;
                    wait_d  = 1'b1;
                end
            end else begin
                cache_d = bus.sdram_dout;
                caddr_d = fa_q;
                valid_d = 1'b1;
                pf_d    = 1'b0;
                pend_d  = 1'b0;
                raddr_d = addr_w;
                state_d = IDLE;
                if (!pf_q || pend_w) begin
                    if (fa_q == addr_w[26:2]) begin
                        din_d  = fill_half;
                        wait_d = 1'b0;
`ifdef CART_UPLOAD_PREFETCH_EN
                        if (addr_w[1]) begin
                            state_d = REQ;
                            req_d   = 1'b1;
                            pf_d    = 1'b1;
                            fa_d    = fa_q + 25'd1;
                        end
`endif
                    end else begin
                        wait_d  = 1'b1;
                        req_d   = 1'b1;
                        fa_d    = addr_w[26:2];
                        state_d = REQ;
                    end
                end
            end
            DRAIN: if (bus.sdram_ready) begin
                state_d = IDLE;
                pf_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (req_d) saddr_d = {fa_d, 2'b00} + BASE_ADDR;
    end

    // State registers; reset drops any outstanding access without waiting for SDRAM
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            act_q   <= 1'b0;
            pf_q    <= 1'b0;
            pend_q  <= 1'b0;
            din_q   <= '0;
            saddr_q <= '0;
            raddr_q <= '0;
            cache_q <= '0;
            caddr_q <= '0;
            fa_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            act_q   <= act_d;
            pf_q    <= pf_d;
            pend_q  <= pend_d;
            din_q   <= din_d;
            saddr_q <= saddr_d;
            raddr_q <= raddr_d;
            cache_q <= cache_d;
            caddr_q <= caddr_d;
            fa_q    <= fa_d;
        end
    end
endmodule

// File: tb/tb_cart_upload.sv
// tb_cart_upload: directed scoreboard bench for cart_upload (default build, no prefetch)
module tb_cart_upload;
    logic clk1x = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int req_cnt = 0;
    int exp_reqs = 0;
    logic [15:0] exp_q[$];

    cart_upload_if bus();

    cart_upload #(.BASE_ADDR(27'd8388608)) dut (
        .clk1x(clk1x),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk1x = ~clk1x;

    // Count every cycle the request pulse is high
    always @(posedge clk1x) if (bus.sdram_req === 1'b1) req_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {16'd0, bus.ioctl_din}, {16'd0, e});
        end
    endtask

    task automatic strobe(input logic [26:0] a, input logic [31:0] word, input bit push);
        if (push) exp_q.push_back(a[1] ? word[31:16] : word[15:0]);
        @(negedge clk1x);
        bus.ioctl_addr = a;
        bus.ioctl_rd = 1'b1;
        @(negedge clk1x);
        bus.ioctl_rd = 1'b0;
    endtask

    task automatic ready_pulse(input logic [31:0] data);
        bus.sdram_ready = 1'b1;
        bus.sdram_dout = data;
        @(negedge clk1x);
        bus.sdram_ready = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        for (int i = 0; i < 20 && bus.ioctl_wait !== 1'b0; i++) @(negedge clk1x);
        chk(tag, {31'd0, bus.ioctl_wait}, 32'd0);
    endtask

    task automatic miss_rd(input logic [26:0] a, input logic [31:0] word, input logic [26:0] exp_addr,
                           input int lat, input string tag);
        exp_reqs++;
        strobe(a, word, 1'b1);
        chk({tag, "_wait_set"}, {31'd0, bus.ioctl_wait}, 32'd1);
        chk({tag, "_req"}, {31'd0, bus.sdram_req}, 32'd1);
        chk({tag, "_addr"}, {5'd0, bus.sdram_addr}, {5'd0, exp_addr});
        @(negedge clk1x);
        chk({tag, "_req_pulse"}, {31'd0, bus.sdram_req}, 32'd0);
        repeat (lat - 1) @(negedge clk1x);
        ready_pulse(word);
        wait_release({tag, "_wait_clr"});
        pop_chk({tag, "_din"});
    endtask

    task automatic hit_rd(input logic [26:0] a, input logic [31:0] word, input string tag);
        int c;
        c = req_cnt;
        strobe(a, word, 1'b1);
        chk({tag, "_wait"}, {31'd0, bus.ioctl_wait}, 32'd0);
        pop_chk({tag, "_din"});
        @(negedge clk1x);
        chk({tag, "_wait_after"}, {31'd0, bus.ioctl_wait}, 32'd0);
        chk({tag, "_noreq"}, req_cnt, c);
    endtask

    initial begin
        bus.upload_active = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_rd = 1'b0;
        bus.sdram_ready = 1'b0;
        bus.sdram_dout = '0;
        repeat (3) @(negedge clk1x);
        chk("rst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("rst_din", {16'd0, bus.ioctl_din}, 32'd0);
        chk("rst_req", {31'd0, bus.sdram_req}, 32'd0);
        chk("rst_addr", {5'd0, bus.sdram_addr}, 32'd0);
        chk("rnw", {31'd0, bus.sdram_rnw}, 32'd1);
        reset = 1'b0;
        bus.upload_active = 1'b1;
        repeat (2) @(negedge clk1x);
        miss_rd(27'd0, 32'hDEADBEEF, 27'h0800000, 3, "rd0");
        hit_rd(27'd2, 32'hDEADBEEF, "rd2_hit");
        miss_rd(27'd6, 32'hCAFE1234, 27'h0800004, 1, "rd6");
        hit_rd(27'd4, 32'hCAFE1234, "rd4_hit");
        exp_reqs++;
        strobe(27'h10, 32'd0, 1'b0);
        chk("drop_wait_set", {31'd0, bus.ioctl_wait}, 32'd1);
        @(negedge clk1x);
        bus.upload_active = 1'b0;
        @(negedge clk1x);
        chk("drop_wait_clr", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("drop_din", {16'd0, bus.ioctl_din}, 32'h1234);
        repeat (9) @(negedge clk1x);
        ready_pulse(32'h12345678);
        chk("drain_din", {16'd0, bus.ioctl_din}, 32'h1234);
        chk("drain_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        bus.upload_active = 1'b1;
        repeat (2) @(negedge clk1x);
        miss_rd(27'd2, 32'hDEADBEEF, 27'h0800000, 2, "rd2_after_drop");
        bus.upload_active = 1'b0;
        repeat (2) @(negedge clk1x);
        bus.upload_active = 1'b1;
        repeat (2) @(negedge clk1x);
        miss_rd(27'd0, 32'hDEADBEEF, 27'h0800000, 1, "rd0_new_session");
        exp_reqs++;
        strobe(27'h20, 32'd0, 1'b0);
        chk("rstw_wait_set", {31'd0, bus.ioctl_wait}, 32'd1);
        @(negedge clk1x);
        #2 reset = 1'b1;
        #1;
        chk("arst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("arst_din", {16'd0, bus.ioctl_din}, 32'd0);
        chk("arst_req", {31'd0, bus.sdram_req}, 32'd0);
        chk("arst_addr", {5'd0, bus.sdram_addr}, 32'd0);
        @(negedge clk1x);
        reset = 1'b0;
        repeat (2) @(negedge clk1x);
        ready_pulse(32'hFFFFFFFF);
        chk("stale_ready_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("stale_ready_din", {16'd0, bus.ioctl_din}, 32'd0);
        miss_rd(27'd0, 32'hDEADBEEF, 27'h0800000, 2, "rd0_after_reset");
        miss_rd(27'h7FFFFFE, 32'h89AB4567, 27'h07FFFFC, 2, "rd_wrap");
        miss_rd(27'd0, 32'h0BADF00D, 27'h0800000, 1, "rd0_after_wrap");
        @(negedge clk1x);
        chk("req_total", req_cnt, exp_reqs);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
